// File: rtl/fpu_sp_pkg.sv
// Shared constants and FSM encoding for the single-precision divider.
package fpu_sp_pkg;

    localparam int unsigned BIAS    = 127;
    localparam int unsigned EXP_MAX = 255;
    localparam int unsigned MANT_W  = 24;
    localparam int unsigned QUOT_W  = 25;

    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef enum logic [1:0] {
        StIdle,
        StDivide,
        StNorm,
        StDone
    } state_e;

endpackage

// File: rtl/fpu_sp_div_core.sv
// Restoring radix-2 mantissa divider: QUOT_W quotient bits of (ma << 24) / mb, one per cycle.
module fpu_sp_div_core
    import fpu_sp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [MANT_W-1:0] ma_i,
    input  logic [MANT_W-1:0] mb_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [QUOT_W-1:0] quot_o
);

    logic [QUOT_W-1:0] rem_q, rem_d;
    logic [QUOT_W-1:0] quot_q, quot_d;
    logic [MANT_W-1:0] mb_q, mb_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              q_bit;
    logic [QUOT_W-1:0] diff;

    assign busy_o = busy_q;
    assign quot_o = quot_q;
    // High during the cycle whose edge shifts in the final quotient bit.
    assign done_o = busy_q && (cnt_q == 5'(QUOT_W - 1));

    always_comb begin
        q_bit  = rem_q >= {1'b0, mb_q};
        diff   = rem_q - {1'b0, mb_q};
        rem_d  = rem_q;
        quot_d = quot_q;
        mb_d   = mb_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start_i) begin
            rem_d  = {1'b0, ma_i};
            mb_d   = mb_i;
            quot_d = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            // Remainder stays below mb, so the doubled value never exceeds QUOT_W bits.
            rem_d  = (q_bit ? diff : rem_q) << 1;
            quot_d = {quot_q[QUOT_W-2:0], q_bit};
            if (done_o) begin
                cnt_d  = '0;
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quot_q <= '0;
            mb_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            mb_q   <= mb_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/fpu_sp_divider.sv
// IEEE-754 single-precision divider: flush-to-zero inputs, truncating, valid/ready handshake.
module fpu_sp_divider
    import fpu_sp_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             underflow,
    output logic             div_by_zero,
    output logic             invalid
);

    state_e            state_q, state_d;
    logic              sign_q, sign_d;
    logic signed [9:0] exp_q, exp_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [3:0]        flags_q, flags_d;  // {overflow, underflow, div_by_zero, invalid}
    logic              a_zero, b_zero, start;
    logic signed [9:0] norm_exp;
    logic [22:0]       norm_mant;
    logic              core_busy, core_done;
    logic [QUOT_W-1:0] quot;

    assign a_zero = (A[30:23] == 8'd0);
    assign b_zero = (B[30:23] == 8'd0);
    assign start  = in_valid && (state_q == StIdle) && !a_zero && !b_zero;

    fpu_sp_div_core u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .ma_i    ({1'b1, A[22:0]}),
        .mb_i    ({1'b1, B[22:0]}),
        .busy_o  (core_busy),
        .done_o  (core_done),
        .quot_o  (quot)
    );

    assign norm_exp  = quot[QUOT_W-1] ? exp_q : exp_q - 10'sd1;
    assign norm_mant = quot[QUOT_W-1] ? quot[23:1] : quot[22:0];

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        result_d = result_q;
        flags_d  = flags_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sign_d = A[31] ^ B[31];
                    if (b_zero && !a_zero) begin
                        result_d = {sign_d, 8'hFF, 23'd0};
                        flags_d  = 4'b0010;
                        state_d  = StDone;
                    end else if (a_zero && b_zero) begin
                        result_d = QNAN;
                        flags_d  = 4'b0001;
                        state_d  = StDone;
                    end else if (a_zero) begin
                        result_d = {sign_d, 31'd0};
                        flags_d  = 4'b0000;
                        state_d  = StDone;
                    end else begin
                        exp_d   = $signed({2'b00, A[30:23]}) - $signed({2'b00, B[30:23]})
                                  + $signed(10'(BIAS));
                        state_d = StDivide;
                    end
                end
            end
            StDivide: begin
                if (core_done) begin
                    state_d = StNorm;
                end else if (!core_busy) begin
                    state_d = StIdle;
                end
            end
            StNorm: begin
                state_d = StDone;
                if (norm_exp >= $signed(10'(EXP_MAX))) begin
                    result_d = {sign_q, 8'hFF, 23'd0};
                    flags_d  = 4'b1000;
                end else if (norm_exp <= 10'sd0) begin
                    result_d = {sign_q, 31'd0};
                    flags_d  = 4'b0100;
                end else begin
                    result_d = {sign_q, norm_exp[7:0], norm_mant};
                    flags_d  = 4'b0000;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign in_ready    = (state_q == StIdle);
    assign out_valid   = (state_q == StDone);
    assign result      = result_q;
    assign overflow    = flags_q[3];
    assign underflow   = flags_q[2];
    assign div_by_zero = flags_q[1];
    assign invalid     = flags_q[0];

endmodule

// File: tb/tb_fpu_sp_divider.sv
// Randomised and directed checks of fpu_sp_divider against an arithmetic reference model.
module tb_fpu_sp_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        overflow, underflow, div_by_zero, invalid;
    logic [3:0]  obs_flags;

    int n_checks = 0;
    int n_errors = 0;

    assign obs_flags = {overflow, underflow, div_by_zero, invalid};

    always #5 clk = ~clk;

    fpu_sp_divider #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .A           (A),
        .B           (B),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .overflow    (overflow),
        .underflow   (underflow),
        .div_by_zero (div_by_zero),
        .invalid     (invalid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Flags packed as {overflow, underflow, div_by_zero, invalid}; lat = edges after accept.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [3:0] f,
                                    output int lat);
        int              ea, eb, e;
        longint unsigned ma, mb, q, mant;
        logic            s;
        s   = a[31] ^ b[31];
        ea  = int'(a[30:23]);
        eb  = int'(b[30:23]);
        f   = 4'b0000;
        r   = '0;
        lat = 0;
        if (eb == 0 && ea != 0) begin
            r = {s, 8'hFF, 23'd0};
            f = 4'b0010;
        end else if (ea == 0 && eb == 0) begin
            r = 32'h7FC00000;
            f = 4'b0001;
        end else if (ea == 0) begin
            r = {s, 31'd0};
        end else begin
            lat  = 26;
            ma   = 64'(a[22:0]) + (64'd1 << 23);
            mb   = 64'(b[22:0]) + (64'd1 << 23);
            q    = (ma << 24) / mb;
            e    = ea - eb + 127;
            if (q >= (64'd1 << 24)) begin
                mant = (q >> 1) & 64'h7FFFFF;
            end else begin
                mant = q & 64'h7FFFFF;
                e    = e - 1;
            end
            if (e >= 255) begin
                r = {s, 8'hFF, 23'd0};
                f = 4'b1000;
            end else if (e <= 0) begin
                r = {s, 31'd0};
                f = 4'b0100;
            end else begin
                r = {s, e[7:0], mant[22:0]};
            end
        end
    endfunction

    // One transaction; literal expectations override the model for directed cases.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int stall,
                         input bit use_lit, input logic [31:0] lit_res,
                         input logic [3:0] lit_flags);
        logic [31:0] exp_res, held_res;
        logic [3:0]  exp_flags, held_flags;
        int          exp_lat, lat;
        ref_div(a, b, exp_res, exp_flags, exp_lat);
        if (use_lit) begin
            exp_res   = lit_res;
            exp_flags = lit_flags;
        end
        @(negedge clk);
        A        = a;
        B        = b;
        in_valid = 1'b1;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        // Garbage on the inputs while busy must be ignored.
        A        = $urandom;
        B        = $urandom;
        in_valid = 1'($urandom_range(0, 1));
        lat      = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        check("out_valid_seen", 32'(out_valid), 32'd1);
        check("latency", 32'(lat), 32'(exp_lat));
        check("result", result, exp_res);
        check("flags", 32'(obs_flags), 32'(exp_flags));
        held_res   = result;
        held_flags = obs_flags;
        repeat (stall) begin
            @(posedge clk);
            #1;
            check("stall_result", result, held_res);
            check("stall_flags", 32'(obs_flags), 32'(held_flags));
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("valid_drop", 32'(out_valid), 32'd0);
        check("in_ready_back", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          seen;

        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_result", result, 32'd0);
        check("rst_flags", 32'(obs_flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(32'h40C00000, 32'h40000000, 0, 1'b1, 32'h40400000, 4'b0000);
        do_op(32'h3F800000, 32'h40400000, 0, 1'b1, 32'h3EAAAAAA, 4'b0000);
        do_op(32'h3F800000, 32'h00000000, 0, 1'b1, 32'h7F800000, 4'b0010);
        do_op(32'h00000000, 32'h00000000, 0, 1'b1, 32'h7FC00000, 4'b0001);
        do_op(32'h80000000, 32'h3F800000, 0, 1'b1, 32'h80000000, 4'b0000);
        do_op(32'h7F000000, 32'h00800000, 0, 1'b1, 32'h7F800000, 4'b1000);
        do_op(32'h00800000, 32'h7F000000, 0, 1'b1, 32'h00000000, 4'b0100);
        do_op(32'h40C00000, 32'h40000000, 10, 1'b1, 32'h40400000, 4'b0000);

        // Reset in the middle of the mantissa iteration.
        @(negedge clk);
        A        = 32'h40C00000;
        B        = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_flags", 32'(obs_flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            seen = seen | int'(out_valid);
        end
        check("no_ghost_result", 32'(seen), 32'd0);
        do_op(32'hC0C00000, 32'h40000000, 0, 1'b1, 32'hC0400000, 4'b0000);

        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) != 0) ra[30:23] = 8'($urandom_range(90, 164));
            if ($urandom_range(0, 3) != 0) rb[30:23] = 8'($urandom_range(90, 164));
            if ($urandom_range(0, 15) == 0) ra[30:23] = 8'd0;
            if ($urandom_range(0, 15) == 0) rb[30:23] = 8'd0;
            do_op(ra, rb, int'($urandom_range(0, 3)), 1'b0, 32'd0, 4'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fpu_sp_divider.md
FPU_SP_DIVIDER -- requirements
Module: fpu_sp_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width; only 32 (IEEE-754 single) is supported.
REQ-002 SHALL have clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have in_valid  input  1  A/B present; in_ready  output  1  divider can accept.
REQ-005 SHALL have A  input  WIDTH  dividend; B  input  WIDTH  divisor.
REQ-006 SHALL have out_valid  output  1  result present; out_ready  input  1  consumer accepts.
REQ-007 SHALL have result  output  WIDTH  quotient A/B.
REQ-008 SHALL have overflow, underflow, div_by_zero, invalid  output  1 each  status flags, valid with result.

Function
REQ-009 SHALL use FSM states IDLE, DIVIDE, NORM, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-010 SHALL accept on clk edge with in_valid&in_ready, capturing A, B; sign = A[31]^B[31].
REQ-011 SHALL treat exponent field 0 as zero operand (flush-to-zero, fraction ignored); otherwise mantissa = {1, frac[22:0]}.
REQ-012 SHALL, for special cases at accept, go IDLE->DONE directly (out_valid one cycle after accept): B zero & A nonzero -> {sign,8'hFF,23'd0}, div_by_zero=1; A zero & B zero -> 32'h7FC00000, invalid=1; A zero & B nonzero -> {sign,31'd0}, no flags.
REQ-013 SHALL otherwise go IDLE->DIVIDE, computing temp exponent = EA - EB + 127 as 10-bit signed.
REQ-014 SHALL run restoring radix-2 division in DIVIDE: one quotient bit per cycle, exactly 25 cycles, producing q[24:0] of (Ma<<24)/Mb; then NORM for 1 cycle.
REQ-015 SHALL normalize in NORM: q[24]=1 -> mantissa q[23:1], exponent unchanged; q[24]=0 -> mantissa q[22:0], exponent-1; remaining bits truncated (no rounding).
REQ-016 SHALL, on final exponent >= 255, output {sign,8'hFF,23'd0} with overflow=1; on final exponent <= 0, output {sign,31'd0} with underflow=1; else {sign,exp[7:0],mantissa}.
REQ-017 SHALL give normal-path latency 26 cycles: out_valid rises after 26th rising edge following accept edge.
REQ-018 SHALL hold result and flags stable while out_valid & !out_ready; DONE->IDLE on out_valid&out_ready.
REQ-019 SHALL assert at most one flag per result; flags 0 whenever out_valid=0 not required (undefined), but registered values held until next result.
REQ-020 SHALL ignore A, B, in_valid outside IDLE; no back-to-back acceptance in the handoff cycle (in_ready returns 1 the cycle after DONE exits).

Reset
REQ-021 SHALL, on rst_n=0 at any time including mid-DIVIDE, immediately enter IDLE with out_valid=0, in_ready=1 after release, result=0, all flags=0, quotient/remainder/counter=0.
REQ-022 SHALL discard any in-flight operation on reset; no result emerges for it.

Structure
REQ-023 SHALL place in shared package fpu_sp_pkg: BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000, MANT_W=24, QUOT_W=25, FSM state enum.
REQ-024 SHALL implement iterative mantissa division in sub-module fpu_sp_div_core (start, busy, done, 25-bit quotient, 5-bit step counter); top holds FSM, exponent, specials, handshake.

Verification
REQ-025 SHALL test 0x40C00000 / 0x40000000 -> result 0x40400000, no flags, out_valid 26 cycles after accept.
REQ-026 SHALL test 0x3F800000 / 0x40400000 -> 0x3EAAAAAA (truncated), no flags.
REQ-027 SHALL test 0x3F800000 / 0x00000000 -> 0x7F800000, div_by_zero=1, latency 1; 0x00000000/0x00000000 -> 0x7FC00000, invalid=1.
REQ-028 SHALL test 0x7F000000 / 0x00800000 -> 0x7F800000, overflow=1; 0x00800000 / 0x7F000000 -> 0x00000000, underflow=1.
REQ-029 SHALL test out_ready=0 for 10 cycles in DONE -> result/flags stable, in_ready=0, single transfer on release.
REQ-030 SHALL test rst_n pulsed low at DIVIDE step 12 -> out_valid=0, result=0 immediately; next operation 0xC0C00000/0x40000000 -> 0xC0400000.
